// File: rtl/countdown_timer.sv
// Loadable down-counting timer with one-shot / auto-reload modes and a pause hold.
// All outputs come straight from registers; busy and done decode the state register.
module countdown_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             start,
    input  logic             pause,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] preset_q, preset_d;
    logic             tc_q, tc_d;

    logic startable;
    assign startable = (state_q == IDLE) || (state_q == DONE);

    // Priority: load > start > pause > countdown; tc defaults low every cycle.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        preset_d = preset_q;
        tc_d     = 1'b0;

        if (load) begin
            count_d  = load_data;
            preset_d = load_data;
            state_d  = IDLE;
        end else if (start && startable) begin
            if (preset_q == '0) begin
                count_d = '0;
                state_d = DONE;
                tc_d    = 1'b1;
            end else begin
                count_d = preset_q;
                state_d = RUN;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (pause) begin
                        state_d = HOLD;
                    end else if (count_q > WIDTH'(1)) begin
                        count_d = count_q - WIDTH'(1);
                    end else if (count_q == WIDTH'(1)) begin
                        tc_d = 1'b1;
                        if (auto_reload) begin
                            count_d = preset_q;
                        end else begin
                            count_d = '0;
                            state_d = DONE;
                        end
                    end else begin
                        state_d = DONE;
                    end
                end
                HOLD: begin
                    if (!pause) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    count_d = '0;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            preset_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            preset_q <= preset_d;
            tc_q     <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = (state_q == RUN) || (state_q == HOLD);
    assign done  = (state_q == DONE);

endmodule
